// File: rtl/raster_frame_streamer_if.sv
// Block-RAM read port plus outgoing raster-pixel stream, grouped for the frame streamer.
// The streamer takes the master modport; the RAM and the pixel consumer sit on the slave side.
interface raster_frame_streamer_if #(
  parameter int pixel_depth = 8,
  parameter int addr_width  = 21
);
  logic                   mem_en;
  logic [addr_width-1:0]  mem_addr;
  logic [pixel_depth-1:0] mem_dout;
  logic                   out_valid;
  logic                   out_ready;
  logic [pixel_depth-1:0] out_data;
  logic                   out_sof;
  logic                   out_eol;
  logic                   out_eof;

  modport master (
    output mem_en, mem_addr,
    input  mem_dout,
    output out_valid, out_data, out_sof, out_eol, out_eof,
    input  out_ready
  );

  modport slave (
    input  mem_en, mem_addr,
    output mem_dout,
    input  out_valid, out_data, out_sof, out_eol, out_eof,
    output out_ready
  );
endinterface

// File: rtl/raster_frame_streamer.sv
// Streams one stored frame out of a single-port block RAM as row-major raster beats.
// Reads run ahead of the consumer by at most two beats, held in a 2-entry tagged FIFO.
module raster_frame_streamer #(
  parameter int frame_width  = 640,
  parameter int frame_height = 480,
  parameter int pixel_depth  = 8,
  parameter int addr_width   = 21
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  raster_frame_streamer_if.master bus
);
  localparam int total = frame_width * frame_height;
  localparam int cnt_w = $clog2(total + 1);
  localparam int x_w   = $clog2(frame_width);
  localparam logic [cnt_w-1:0] total_cnt = cnt_w'(total);
  localparam logic [cnt_w-1:0] last_idx  = cnt_w'(total - 1);
  localparam logic [x_w-1:0]   last_x    = x_w'(frame_width - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t state, state_nxt;

  logic [addr_width-1:0]  base_q;
  logic [cnt_w-1:0]       rd_idx;
  logic [cnt_w-1:0]       emit_idx;
  logic [x_w-1:0]         rd_x;
  logic                   vld_p1;
  logic [x_w-1:0]         x_p1;
  logic [pixel_depth-1:0] fifo_data [2];
  logic [x_w-1:0]         fifo_x    [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             fifo_cnt;
  logic [2:0]             occupancy;
  logic                   issue;
  logic                   pop;
  logic                   last_pop;
  logic                   accept_start;

  function automatic logic [x_w-1:0] next_x(input logic [x_w-1:0] x);
    return (x == last_x) ? '0 : x + x_w'(1);
  endfunction

  assign accept_start = (state == IDLE) && start;
  assign pop          = (fifo_cnt != 2'd0) && bus.out_ready;
  assign last_pop     = pop && (emit_idx == last_idx);
  // Beats held or about to land once this cycle's pop leaves; issue only while below two.
  assign occupancy    = {1'b0, fifo_cnt} + {2'b00, vld_p1} - {2'b00, pop};

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = STREAM;
      end
      STREAM: begin
        issue = (rd_idx < total_cnt) && (occupancy < 3'd2);
        if (issue && (rd_idx == last_idx)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_pop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign bus.mem_en   = issue;
  assign bus.mem_addr = base_q + addr_width'(rd_idx);

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_idx   <= '0;
      emit_idx <= '0;
      rd_x     <= '0;
      vld_p1   <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      done     <= 1'b0;
    end else begin
      done     <= (state == DRAIN) && last_pop;
      vld_p1   <= issue;
      fifo_cnt <= fifo_cnt + {1'b0, vld_p1} - {1'b0, pop};
      if (vld_p1) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      if (accept_start) begin
        rd_idx   <= '0;
        emit_idx <= '0;
        rd_x     <= '0;
      end else begin
        if (issue) begin
          rd_idx <= rd_idx + cnt_w'(1);
          rd_x   <= next_x(rd_x);
        end
        if (pop) emit_idx <= emit_idx + cnt_w'(1);
      end
    end
  end

  // Read stage p1: RAM data and its column tag land in the FIFO one edge after the request.
  always_ff @(posedge clk) begin
    if (accept_start) base_q <= base_addr;
    x_p1 <= rd_x;
    if (vld_p1) begin
      fifo_data[wr_ptr] <= bus.mem_dout;
      fifo_x[wr_ptr]    <= x_p1;
    end
  end

  // Output stage: head of FIFO, forced to zero whenever nothing is held.
  assign bus.out_valid = (fifo_cnt != 2'd0);
  assign bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
  assign bus.out_sof   = bus.out_valid && (emit_idx == '0);
  assign bus.out_eol   = bus.out_valid && (fifo_x[rd_ptr] == last_x);
  assign bus.out_eof   = bus.out_valid && (emit_idx == last_idx);
endmodule

// File: tb/tb_raster_frame_streamer.sv
// Randomised bench for raster_frame_streamer: RAM model, ready patterns and a frame-order scoreboard.
module tb_raster_frame_streamer;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int PD = 8;
  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          clr;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic          done;

  raster_frame_streamer_if #(.pixel_depth(PD), .addr_width(AW)) bus ();

  raster_frame_streamer #(
    .frame_width(W), .frame_height(H), .pixel_depth(PD), .addr_width(AW)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rmode = 0;
  int pcnt = 0;

  int acc, issued, done_cnt;
  int first_en, first_beat, last_beat, done_cyc;
  logic [AW-1:0] base_m;
  logic          stall_prev;
  logic          prev_done;
  logic [10:0]   prev_word;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PD-1:0] pix(input logic [AW-1:0] a);
    return a[7:0] ^ a[20:13];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.mem_en) bus.mem_dout <= pix(bus.mem_addr);

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       begin bus.out_ready = ((pcnt % 3) == 0); pcnt++; end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard: the k-th accepted beat of a frame is pixel k, addresses advance linearly mod 2^AW.
  always @(negedge clk) begin
    int k;
    int popi;
    logic [AW-1:0] ea;
    logic [2:0] ef;
    logic [2:0] gf;
    popi = (bus.out_valid && bus.out_ready) ? 1 : 0;
    if (bus.mem_en) begin
      ea = base_m + AW'(issued % N);
      chk("addr", 32'(bus.mem_addr), 32'(ea));
      chk("outstanding", ((issued + 1 - acc - popi) <= 2) ? 1 : 0, 1);
      if (issued == 0) first_en = cyc;
      issued++;
    end
    if (stall_prev) begin
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_word", 32'({bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof}), 32'(prev_word));
    end
    if (popi == 1) begin
      k  = acc % N;
      ef = {k == 0, (k % W) == W - 1, k == N - 1};
      gf = {bus.out_sof, bus.out_eol, bus.out_eof};
      chk("data", 32'(bus.out_data), 32'(pix(base_m + AW'(k))));
      chk("flags", 32'(gf), 32'(ef));
      if (acc == 0) first_beat = cyc;
      last_beat = cyc;
      acc++;
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    prev_word  = {bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof};
    if (done) begin
      chk("done_width", 32'(prev_done), 0);
      chk("done_pos", acc % N, 0);
      done_cnt++;
      done_cyc = cyc;
    end
    prev_done = done;
  end

  task automatic arm(input logic [AW-1:0] b, input int mode, output int t0, output int d0);
    rmode = mode;
    pcnt = 0;
    @(posedge clk); #1;
    acc = 0;
    issued = 0;
    base_m = b;
    stall_prev = 1'b0;
    d0 = done_cnt;
    base_addr = b;
    start = 1'b1;
    t0 = cyc;
  endtask

  task automatic run_frame(input logic [AW-1:0] b, input int mode, input bit timing);
    int t0, d0, n;
    arm(b, mode, t0, d0);
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_done", done_cnt - d0, 1);
    chk("beats", acc, N);
    chk("reads", issued, N);
    chk("busy_end", 32'(busy), 0);
    if (timing) begin
      chk("lat_mem_en", first_en - t0, 1);
      chk("lat_first_px", first_beat - t0, 3);
      chk("lat_last_px", last_beat - t0, N + 2);
      chk("lat_done", done_cyc - t0, N + 3);
    end
  endtask

  task automatic clr_mid_frame(input logic [AW-1:0] b);
    int t0, d0, n;
    arm(b, 0, t0, d0);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (acc < 5 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("clr_reach5", (acc >= 5) ? 1 : 0, 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_valid", 32'(bus.out_valid), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_mem_en", 32'(bus.mem_en), 0);
    repeat (N + 5) @(posedge clk);
    #1;
    chk("clr_no_done", done_cnt - d0, 0);
    chk("clr_idle_valid", 32'(bus.out_valid), 0);
  endtask

  task automatic start_held(input logic [AW-1:0] b);
    int t0, d0, n;
    arm(b, 0, t0, d0);
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (done_cnt < d0 + 2 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_frames", done_cnt - d0, 2);
    chk("held_beats", acc, 2 * N);
    chk("held_done2_cyc", done_cyc - t0, 2 * N + 6);
    chk("held_busy_end", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    acc = 0; issued = 0; done_cnt = 0;
    first_en = 0; first_beat = 0; last_beat = 0; done_cyc = 0;
    base_m = '0; stall_prev = 1'b0; prev_done = 1'b0; prev_word = '0;
    clr = 1'b1;
    start = 1'b0;
    base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_flags", 32'({bus.out_sof, bus.out_eol, bus.out_eof}), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    clr = 1'b0;

    run_frame('0, 0, 1'b1);
    run_frame('0, 1, 1'b0);
    run_frame(AW'((1 << AW) - 4), 1, 1'b0);
    clr_mid_frame(AW'(100));
    run_frame(AW'(100), 0, 1'b1);
    start_held(AW'(7));
    repeat (4) run_frame(AW'($urandom), 2, 1'b0);
    run_frame(AW'((1 << AW) - 2), 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
